// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller: accepts a binary value, converts it to
// BCD with a bit-serial double-dabble and time-multiplexes the digits onto a shared decoder.
module seg7_scan_ctrl #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned DATA_W     = 14,
  parameter int unsigned SCAN_DIV   = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [DATA_W-1:0]     load_data,
  input  logic                  blank_lz,
  output logic [3:0]            dig_bcd,
  output logic [NUM_DIGITS-1:0] dig_sel,
  output logic                  overflow
);

  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam int unsigned DISP_W = NUM_DIGITS * 4;
  localparam int unsigned BCD_W  = DISP_W + 4;
  localparam int unsigned CNT_W  = $clog2(DATA_W + 1);
  localparam int unsigned PRE_W  = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [63:0] LIMIT  = pow10(NUM_DIGITS);

  typedef enum logic {IDLE, CONV} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   bin_q, bin_step;
  logic [BCD_W-1:0]    bcd_q, bcd_step, bcd_adj;
  logic [CNT_W-1:0]    cnt_q;
  logic [DISP_W-1:0]   disp_q;
  logic                last_step;
  logic                take;

  logic [PRE_W-1:0]      pre_q, pre_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_DIGITS-1:0] lz;
  logic                  zero_run;
  logic [3:0]            nib;
  logic                  nib_blank;

  assign take      = (state_q == IDLE) && load_valid && load_ready;
  assign last_step = (cnt_q == CNT_W'(DATA_W - 1));

  // One double-dabble step: add 3 to nibbles >= 5, then shift in the next binary bit
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i <= int'(NUM_DIGITS); i++) begin
      if (bcd_adj[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_adj[i*4 +: 4] + 4'd3;
    end
    bcd_step = {bcd_adj[BCD_W-2:0], bin_q[DATA_W-1]};
    bin_step = {bin_q[DATA_W-2:0], 1'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (take) state_d = CONV;
      CONV:    if (last_step) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Conversion datapath and handshake; display regs update only on the final step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      disp_q     <= '0;
      overflow   <= 1'b0;
      load_ready <= 1'b1;
    end else if (take) begin
      bin_q      <= load_data;
      bcd_q      <= '0;
      cnt_q      <= '0;
      overflow   <= (64'(load_data) >= LIMIT);
      load_ready <= 1'b0;
    end else if (state_q == CONV) begin
      bin_q <= bin_step;
      bcd_q <= bcd_step;
      cnt_q <= cnt_q + CNT_W'(1);
      if (last_step) begin
        load_ready <= 1'b1;
        if (!overflow) disp_q <= bcd_step[DISP_W-1:0];
      end
    end
  end

  // Scan counters
  always_comb begin
    pre_d = pre_q + PRE_W'(1);
    idx_d = idx_q;
    if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
      pre_d = '0;
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Leading-zero mask: digit k is blankable when it and every higher digit is zero
  always_comb begin
    lz       = '0;
    zero_run = 1'b1;
    for (int k = int'(NUM_DIGITS) - 1; k >= 1; k--) begin
      zero_run = zero_run && (disp_q[k*4 +: 4] == 4'd0);
      lz[k]    = zero_run;
    end
  end

  always_comb begin
    nib       = 4'hF;
    nib_blank = 1'b0;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      if (idx_d == IDX_W'(k)) begin
        nib       = disp_q[k*4 +: 4];
        nib_blank = lz[k] && blank_lz;
      end
    end
  end

  // Outputs track the next counter state so they line up with the prescaler phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q   <= '0;
      idx_q   <= '0;
      dig_sel <= '1;
      dig_bcd <= 4'hF;
    end else begin
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      dig_sel <= (pre_d == '0) ? '1 : ~(NUM_DIGITS'(1) << idx_d);
      dig_bcd <= (overflow || nib_blank) ? 4'hF : nib;
    end
  end

endmodule
